// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the five-stage core.
// Generates load-use stalls, redirect flushes, memory-wait holds, execute-stage
// forwarding selects and a sticky memory-wait watchdog flag.
// Optional feature macro: HAZARD_PERF_CNT_EN builds the stall/flush performance
// counters; when undefined the counter outputs are tied to zero.
module hazard_ctrl #(
  parameter int unsigned MAX_WAIT  = 16,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           D_ra,
  input  logic [4:0]           D_rb,
  input  logic [4:0]           E_ra,
  input  logic [4:0]           E_rb,
  input  logic [4:0]           E_rd,
  input  logic [1:0]           E_result_src,
  input  logic                 E_pc_src,
  input  logic [4:0]           M_rd,
  input  logic [4:0]           W_rd,
  input  logic                 M_RegWrite,
  input  logic                 W_RegWrite,
  input  logic                 M_mem_req,
  input  logic                 mem_ready,
  output logic                 F_stall,
  output logic                 D_stall,
  output logic                 D_flush,
  output logic                 E_stall,
  output logic                 E_flush,
  output logic                 M_stall,
  output logic                 W_bubble,
  output logic [1:0]           forward_a,
  output logic [1:0]           forward_b,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              r_mem_timeout;

  logic w_lu;
  logic w_wait_start;
  logic w_wait_hold;
  logic w_f_stall;
  logic w_d_stall;
  logic w_d_flush;
  logic w_e_stall;
  logic w_e_flush;
  logic w_m_stall;
  logic w_w_bubble;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // Load-use: a load in execute whose destination is read in decode (x0 excluded)
  assign w_lu = (E_result_src == RES_LOAD) && (E_rd != 5'd0) &&
                ((E_rd == D_ra) || (E_rd == D_rb));

  // Memory access that misses its single-cycle slot, or an ongoing wait
  assign w_wait_start = (r_state == RUN) && M_mem_req && !mem_ready;
  assign w_wait_hold  = (r_state == MEM_WAIT) && !mem_ready;

  // Next-state and Mealy control decode; memory wait outranks redirect outranks load-use
  always_comb begin
    w_state_nxt = r_state;
    w_f_stall   = 1'b0;
    w_d_stall   = 1'b0;
    w_d_flush   = 1'b0;
    w_e_stall   = 1'b0;
    w_e_flush   = 1'b0;
    w_m_stall   = 1'b0;
    w_w_bubble  = 1'b0;
    if (w_wait_start || w_wait_hold) begin
      // Execute stage is held, so any pending redirect is replayed on release
      w_f_stall   = 1'b1;
      w_d_stall   = 1'b1;
      w_e_stall   = 1'b1;
      w_m_stall   = 1'b1;
      w_w_bubble  = 1'b1;
      w_state_nxt = MEM_WAIT;
    end else begin
      w_state_nxt = RUN;
      if (E_pc_src) begin
        // Dependent instruction is flushed, so no load-use stall is needed
        w_d_flush = 1'b1;
        w_e_flush = 1'b1;
      end else if (w_lu) begin
        w_f_stall = 1'b1;
        w_d_stall = 1'b1;
        w_e_flush = 1'b1;
      end
    end
  end

  // Operand A forwarding select; memory stage has priority over writeback
  always_comb begin
    w_fwd_a = FWD_RF;
    if (M_RegWrite && (M_rd != 5'd0) && (M_rd == E_ra)) begin
      w_fwd_a = FWD_MEM;
    end else if (W_RegWrite && (W_rd != 5'd0) && (W_rd == E_ra)) begin
      w_fwd_a = FWD_WB;
    end
  end

  // Operand B forwarding select; memory stage has priority over writeback
  always_comb begin
    w_fwd_b = FWD_RF;
    if (M_RegWrite && (M_rd != 5'd0) && (M_rd == E_rb)) begin
      w_fwd_b = FWD_MEM;
    end else if (W_RegWrite && (W_rd != 5'd0) && (W_rd == E_rb)) begin
      w_fwd_b = FWD_WB;
    end
  end

  // All pipeline controls are forced inactive while reset is held
  assign F_stall   = rst & w_f_stall;
  assign D_stall   = rst & w_d_stall;
  assign D_flush   = rst & w_d_flush;
  assign E_stall   = rst & w_e_stall;
  assign E_flush   = rst & w_e_flush;
  assign M_stall   = rst & w_m_stall;
  assign W_bubble  = rst & w_w_bubble;
  assign forward_a = rst ? w_fwd_a : FWD_RF;
  assign forward_b = rst ? w_fwd_b : FWD_RF;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Saturating increment of the wait counter
  assign w_wait_inc = (r_wait_cnt == WAIT_LIMIT) ? r_wait_cnt : (r_wait_cnt + WAIT_W'(1));

  // Memory-wait watchdog: counts MEM_WAIT cycles, sticky flag once the limit is hit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else if (w_wait_start) begin
      r_wait_cnt <= '0;
    end else if (r_state == MEM_WAIT) begin
      r_wait_cnt <= w_wait_inc;
      if (w_wait_inc == WAIT_LIMIT) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  assign mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic [CNT_WIDTH-1:0] r_flush_events;

  // Saturating hazard performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_f_stall && !(&r_stall_cycles)) begin
        r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
      end
      if (w_d_flush && !(&r_flush_events)) begin
        r_flush_events <= r_flush_events + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
